// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and EX-stage forward-select bundle between decode and the
// forwarding/hazard unit.
interface fwd_hazard_unit_if #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int SEL_W   = $clog2(DEPTH)
);
    logic                     id_valid;
    logic                     id_flush;
    logic [NUM_SRC*REG_W-1:0] id_rs;
    logic [NUM_SRC-1:0]       id_rs_used;
    logic [REG_W-1:0]         id_rd;
    logic                     id_regwrite;
    logic [SEL_W-1:0]         id_lat;
    logic                     stall;
    logic                     ex_valid;
    logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;

    modport master (
        output id_valid, id_flush, id_rs, id_rs_used, id_rd, id_regwrite, id_lat,
        input  stall, ex_valid, ex_fwd_sel
    );

    modport slave (
        input  id_valid, id_flush, id_rs, id_rs_used, id_rd, id_regwrite, id_lat,
        output stall, ex_valid, ex_fwd_sel
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Scoreboard-based forwarding/hazard unit: tracks age and result latency of every
// in-flight writer, stalls ID on unready producers and registers EX forward selects.
module fwd_hazard_unit #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int SEL_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_unit_if.slave bus
);
    localparam int NUM_REGS = 2 ** REG_W;
    localparam int AGE_W    = $clog2(DEPTH + 1);
    localparam logic [AGE_W-1:0] AGE_RETIRE = AGE_W'(DEPTH);
    localparam logic [SEL_W-1:0] LAT_MAX    = SEL_W'(DEPTH - 1);

    typedef struct packed {
        logic             valid;
        logic [AGE_W-1:0] age;
        logic [SEL_W-1:0] lat;
    } sb_entry_t;

    sb_entry_t                sb_q [NUM_REGS];
    sb_entry_t                sb_d [NUM_REGS];
    logic                     ex_valid_q, ex_valid_d;
    logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_q, ex_fwd_sel_d;

    logic [REG_W-1:0]         src_idx [NUM_SRC];
    logic [NUM_SRC-1:0]       src_live;
    logic [NUM_SRC-1:0]       src_haz;
    logic [NUM_SRC*SEL_W-1:0] src_sel;
    logic [SEL_W-1:0]         lat_norm;
    logic                     hazard;
    logic                     issue;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        src_live = '0;
        src_haz  = '0;
        src_sel  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_idx[k] = bus.id_rs[k*REG_W +: REG_W];
            // An entry at age DEPTH is already in the write-through register file.
            src_live[k] = bus.id_rs_used[k] && (src_idx[k] != '0)
                       && sb_q[src_idx[k]].valid && (sb_q[src_idx[k]].age < AGE_RETIRE);
            if (src_live[k]) begin
                src_sel[k*SEL_W +: SEL_W] = SEL_W'(sb_q[src_idx[k]].age);
                src_haz[k] = sb_q[src_idx[k]].age < AGE_W'(sb_q[src_idx[k]].lat);
            end
        end
    end

    assign hazard    = |src_haz;
    assign issue     = bus.id_valid && !bus.id_flush && !hazard;
    assign bus.stall = bus.id_valid && !bus.id_flush && hazard;

    always_comb begin
        lat_norm = bus.id_lat;
        if (bus.id_lat == '0) begin
            lat_norm = SEL_W'(1);
        end else if (bus.id_lat > LAT_MAX) begin
            lat_norm = LAT_MAX;
        end
    end

    // Aging runs every cycle regardless of stall; the issuing writer then overrides.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            sb_d[r] = sb_q[r];
            if (sb_q[r].valid) begin
                if (sb_q[r].age == AGE_RETIRE) begin
                    sb_d[r].valid = 1'b0;
                end else begin
                    sb_d[r].age = sb_q[r].age + AGE_W'(1);
                end
            end
        end
        if (issue && bus.id_regwrite && (bus.id_rd != '0)) begin
            sb_d[bus.id_rd] = '{valid: 1'b1, age: AGE_W'(1), lat: lat_norm};
        end
    end

    always_comb begin
        ex_valid_d   = issue;
        ex_fwd_sel_d = issue ? src_sel : '0;
    end

    // NOTE: the scoreboard valid bits must reset, so the whole table shares the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                sb_q[r] <= '0;
            end
            ex_valid_q   <= 1'b0;
            ex_fwd_sel_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            for (int r = 0; r < NUM_REGS; r++) begin
                sb_q[r] <= sb_d[r];
            end
            ex_valid_q   <= ex_valid_d;
            ex_fwd_sel_q <= ex_fwd_sel_d;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_fwd_sel = ex_fwd_sel_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: stall checked inline in ID, EX outputs
// checked by a scoreboard queue one cycle after each ID drive.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_W(5), .NUM_SRC(2), .DEPTH(3)) bus ();

    fwd_hazard_unit #(.REG_W(5), .NUM_SRC(2), .DEPTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       exp_v;
        logic [3:0] exp_sel;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Scoreboard: each ID drive pushes the EX outputs expected after the next edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (bus.ex_valid !== mon_e.exp_v || bus.ex_fwd_sel !== mon_e.exp_sel) begin
                n_fail++;
                $display("FAIL %s: ex_valid=%b ex_fwd_sel=%h, expected ex_valid=%b ex_fwd_sel=%h",
                         mon_e.name, bus.ex_valid, bus.ex_fwd_sel, mon_e.exp_v, mon_e.exp_sel);
            end
        end
    end

    task automatic set_id(input logic v, input logic fl, input logic [4:0] rs0,
                          input logic [4:0] rs1, input logic [1:0] used,
                          input logic [4:0] rd, input logic rw, input logic [1:0] lat);
        bus.id_valid    = v;
        bus.id_flush    = fl;
        bus.id_rs       = {rs1, rs0};
        bus.id_rs_used  = used;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_lat      = lat;
    endtask

    task automatic drive(input logic v, input logic fl, input logic [4:0] rs0,
                         input logic [4:0] rs1, input logic [1:0] used,
                         input logic [4:0] rd, input logic rw, input logic [1:0] lat,
                         input logic ev, input logic [1:0] es0, input logic [1:0] es1,
                         input string name);
        @(negedge clk);
        set_id(v, fl, rs0, rs1, used, rd, rw, lat);
        exp_q.push_back('{exp_v: ev, exp_sel: {es1, es0}, name: name});
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_id(1, 0, 5, 5, 2'b11, 5, 1, 2);
        #2;
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.ex_fwd_sel !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ex_valid=%b ex_fwd_sel=%h, expected 0/0",
                     bus.ex_valid, bus.ex_fwd_sel);
        end
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: stall=%b, expected 0", bus.stall);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.ex_fwd_sel !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_held: ex_valid=%b ex_fwd_sel=%h, expected 0/0",
                     bus.ex_valid, bus.ex_fwd_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_id(0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        drive(1, 0, 0, 0, 2'b00, 5, 1, 1, 1, 0, 0, "b2b_producer");
        drive(1, 0, 5, 0, 2'b01, 0, 0, 0, 1, 1, 0, "b2b_consumer_sel");
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stall: stall=%b, expected 0", bus.stall);
        end
        idle(4);
    endtask

    task automatic test_one_gap;
        drive(1, 0, 0, 0, 2'b00, 5, 1, 1, 1, 0, 0, "gap_producer");
        idle(1);
        drive(1, 0, 0, 5, 2'b10, 0, 0, 0, 1, 0, 2, "gap1_sel_memwb");
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL gap1_stall: stall=%b, expected 0", bus.stall);
        end
        idle(4);
        drive(1, 0, 0, 0, 2'b00, 5, 1, 1, 1, 0, 0, "gap_producer2");
        idle(2);
        drive(1, 0, 0, 5, 2'b10, 0, 0, 0, 1, 0, 0, "gap2_retired_sel");
        idle(4);
    endtask

    task automatic test_load_use;
        drive(1, 0, 0, 0, 2'b00, 7, 1, 2, 1, 0, 0, "load_producer");
        drive(1, 0, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0, "load_use_bubble");
        n_tests++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall_c1: stall=%b, expected 1", bus.stall);
        end
        drive(1, 0, 0, 7, 2'b10, 0, 0, 0, 1, 0, 2, "load_use_sel");
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_stall_c2: stall=%b, expected 0", bus.stall);
        end
        idle(4);
        // lat above DEPTH-1 behaves as a load
        drive(1, 0, 0, 0, 2'b00, 8, 1, 3, 1, 0, 0, "lat_clamp_producer");
        drive(1, 0, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0, "lat_clamp_bubble");
        n_tests++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_clamp_stall: stall=%b, expected 1", bus.stall);
        end
        drive(1, 0, 8, 0, 2'b01, 0, 0, 0, 1, 2, 0, "lat_clamp_sel");
        idle(4);
        // lat of zero behaves as an ALU result
        drive(1, 0, 0, 0, 2'b00, 8, 1, 0, 1, 0, 0, "lat_zero_producer");
        drive(1, 0, 8, 0, 2'b01, 0, 0, 0, 1, 1, 0, "lat_zero_sel");
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_zero_stall: stall=%b, expected 0", bus.stall);
        end
        idle(4);
    endtask

    task automatic test_youngest_writer;
        drive(1, 0, 0, 0, 2'b00, 3, 1, 1, 1, 0, 0, "young_writer_a");
        drive(1, 0, 0, 0, 2'b00, 3, 1, 1, 1, 0, 0, "young_writer_b");
        drive(1, 0, 3, 3, 2'b11, 0, 0, 0, 1, 1, 1, "young_both_sel");
        idle(4);
        drive(1, 0, 0, 0, 2'b00, 0, 1, 2, 1, 0, 0, "r0_writer");
        drive(1, 0, 0, 0, 2'b11, 0, 0, 0, 1, 0, 0, "r0_consumer_sel");
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_stall: stall=%b, expected 0", bus.stall);
        end
        idle(4);
        // reads and rewrites r4: select comes from the older ALU writer
        drive(1, 0, 0, 0, 2'b00, 4, 1, 1, 1, 0, 0, "rw_same_first");
        drive(1, 0, 4, 0, 2'b01, 4, 1, 2, 1, 1, 0, "rw_same_pre_update");
        drive(1, 0, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0, "rw_same_bubble");
        n_tests++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_same_stall: stall=%b, expected 1", bus.stall);
        end
        drive(1, 0, 4, 0, 2'b01, 0, 0, 0, 1, 2, 0, "rw_same_sel");
        idle(4);
    endtask

    task automatic test_flush;
        drive(1, 0, 0, 0, 2'b00, 7, 1, 2, 1, 0, 0, "flush_producer");
        drive(1, 1, 7, 0, 2'b01, 7, 1, 2, 0, 0, 0, "flush_killed");
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: stall=%b, expected 0", bus.stall);
        end
        // entry 7 must still be the original writer at age 2
        drive(1, 0, 7, 0, 2'b01, 0, 0, 0, 1, 2, 0, "flush_entry_kept");
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after_stall: stall=%b, expected 0", bus.stall);
        end
        idle(4);
    endtask

    task automatic test_reset_midop;
        drive(1, 0, 0, 0, 2'b00, 9, 1, 1, 1, 0, 0, "rst_producer");
        drive(1, 0, 9, 0, 2'b01, 10, 1, 2, 1, 1, 0, "rst_pending_load");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        set_id(1, 0, 10, 0, 2'b01, 0, 0, 0);
        #1;
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.ex_fwd_sel !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_async_clear: ex_valid=%b ex_fwd_sel=%h, expected 0/0",
                     bus.ex_valid, bus.ex_fwd_sel);
        end
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stall_in_reset: stall=%b, expected 0", bus.stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1, 0, 10, 9, 2'b11, 0, 0, 0);
        exp_q.push_back('{exp_v: 1'b1, exp_sel: 4'h0, name: "rst_consumer_sel"});
        #1;
        n_tests++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_consumer_stall: stall=%b, expected 0", bus.stall);
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_one_gap();
        test_load_use();
        test_youngest_writer();
        test_flush();
        test_reset_midop();
        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
